// File: rtl/pll_reset_seq_pkg.sv
// Shared types and sizing helpers for the PLL reset sequencer.
// Optional tick divider is enabled by PLL_RESET_SEQ_TICK_EN.
package pll_reset_seq_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam int LOSS_CNT_W = 8;

  // Bits needed to hold max(a, b) - 1 (at least one bit).
  function automatic int cnt_width(input int a, input int b);
    int m;
    int w;
    m = ((a > b) ? a : b) - 1;
    w = 1;
    while ((2 ** w) <= m) w++;
    return w;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_2ff.sv
// Two-flop synchronizer with asynchronous active-high reset to 0.
// Used to bring the raw PLL lock into the CLK domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Qualifies PLL lock, then sequences the system reset release.
// Define PLL_RESET_SEQ_TICK_EN to add the periodic tick strobe in RUN.
module pll_reset_sequencer
  import pll_reset_seq_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 256,
  parameter int TICK_DIV           = 120
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  pll_lock,
  input  logic                  soft_reset_req,
  output logic                  sys_reset,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`ifdef PLL_RESET_SEQ_TICK_EN
  ,
  output logic                  tick
`endif
);

  localparam int CW = cnt_width(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST   = CW'(RST_HOLD_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          lock_s;

  sync_2ff u_lock_sync (
    .clk (CLK),
    .rst (RESET),
    .d   (pll_lock),
    .q   (lock_s)
  );

  // Outputs follow the next state so they move on the same edge as state.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state         <= WAIT_LOCK;
      cnt           <= '0;
      sys_reset     <= 1'b1;
      ready         <= 1'b0;
      lock_loss_cnt <= '0;
    end else begin
      sys_reset <= 1'b1;
      ready     <= 1'b0;
      unique case (state)
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABLE;
            cnt   <= '0;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            if (lock_loss_cnt != '1)
              lock_loss_cnt <= lock_loss_cnt + 1'b1;
          end else if (cnt == HOLD_LAST) begin
            state     <= RUN;
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            if (lock_loss_cnt != '1)
              lock_loss_cnt <= lock_loss_cnt + 1'b1;
          end else if (soft_reset_req) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            sys_reset <= 1'b0;
            ready     <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef PLL_RESET_SEQ_TICK_EN
  localparam int TW = cnt_width(TICK_DIV, TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt;
  logic          stay_run;

  assign stay_run = (state == RUN) && lock_s && !soft_reset_req;

  // Divider restarts from 0 on every entry to RUN.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end else if (stay_run) begin
      tick     <= (tick_cnt == TICK_LAST);
      tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end else begin
      tick_cnt <= '0;
      tick     <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Self-checking bench: countdown reference model plus directed latency checks.
// Covers the tick strobe when PLL_RESET_SEQ_TICK_EN is defined.
module tb_pll_reset_sequencer;

  localparam int L = 4;
  localparam int R = 3;
  localparam int D = 5;

  logic       CLK;
  logic       RESET;
  logic       pll_lock;
  logic       soft_reset_req;
  logic       sys_reset;
  logic       ready;
  logic [7:0] lock_loss_cnt;
`ifdef PLL_RESET_SEQ_TICK_EN
  logic       tick;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pll_reset_sequencer #(
    .LOCK_STABLE_CYCLES (L),
    .RST_HOLD_CYCLES    (R),
    .TICK_DIV           (D)
  ) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .pll_lock       (pll_lock),
    .soft_reset_req (soft_reset_req),
    .sys_reset      (sys_reset),
    .ready          (ready),
    .lock_loss_cnt  (lock_loss_cnt)
`ifdef PLL_RESET_SEQ_TICK_EN
    ,
    .tick           (tick)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: lock history delay line, then a countdown of remaining
  // consecutive locked edges before the system may run.
  int rem;
  bit running;
  int loss;
  int age;
  bit h1, h2;
  bit exp_tick;

  task automatic model_reset();
    rem      = L + R + 1;
    running  = 0;
    loss     = 0;
    age      = 0;
    h1       = 0;
    h2       = 0;
    exp_tick = 0;
  endtask

  task automatic model_step();
    bit ls;
    ls = h2;
    h2 = h1;
    h1 = pll_lock;
    exp_tick = 0;
    if (!ls) begin
      if (running || rem <= R)
        loss = (loss < 255) ? loss + 1 : 255;
      rem     = L + R + 1;
      running = 0;
    end else if (running) begin
      if (soft_reset_req) begin
        running = 0;
        rem     = R;
      end else begin
        age++;
        if (age % D == 0) exp_tick = 1;
      end
    end else begin
      rem--;
      if (rem == 0) begin
        running = 1;
        age     = 0;
      end
    end
  endtask

  always @(posedge CLK or posedge RESET) begin
    if (RESET) model_reset();
    else model_step();
    #1;
    chk("sys_reset", int'(sys_reset), int'(!running));
    chk("ready", int'(ready), int'(running));
    chk("lock_loss_cnt", int'(lock_loss_cnt), loss);
`ifdef PLL_RESET_SEQ_TICK_EN
    chk("tick", int'(tick), int'(exp_tick));
`endif
  end

  function automatic logic sig(input int sel);
    logic v;
    v = 1'b0;
    case (sel)
      0: v = sys_reset;
      1: v = ready;
`ifdef PLL_RESET_SEQ_TICK_EN
      2: v = tick;
`endif
      default: v = 1'b0;
    endcase
    return v;
  endfunction

  // Edges until the selected output equals want; -1 on timeout.
  task automatic wait_for(input int sel, input logic want,
                          input int max, output int n);
    n = -1;
    for (int k = 1; k <= max; k++) begin
      @(posedge CLK);
      #2;
      if (sig(sel) == want) begin
        n = k;
        break;
      end
    end
  endtask

  int n;
  int hi_len, lo_len;

  initial begin
    RESET          = 1'b1;
    pll_lock       = 1'b0;
    soft_reset_req = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    chk("reset_sys_reset", int'(sys_reset), 1);
    chk("reset_ready", int'(ready), 0);
    chk("reset_loss", int'(lock_loss_cnt), 0);

    // Power-up qualification
    @(negedge CLK);
    RESET    = 1'b0;
    pll_lock = 1'b1;
    wait_for(0, 1'b0, 30, n);
    chk("powerup_release_edges", n, 10);
    chk("powerup_ready", int'(ready), 1);
`ifdef PLL_RESET_SEQ_TICK_EN
    wait_for(2, 1'b1, 20, n);
    chk("tick_first", n, 5);
    wait_for(2, 1'b1, 20, n);
    chk("tick_period", n, 5);
`endif

    // Unstable lock never reaches HOLD
    @(negedge CLK);
    RESET    = 1'b1;
    pll_lock = 1'b0;
    @(negedge CLK);
    RESET    = 1'b0;
    pll_lock = 1'b1;
    repeat (3) @(negedge CLK);
    pll_lock = 1'b0;
    repeat (2) @(negedge CLK);
    pll_lock = 1'b1;
    wait_for(0, 1'b0, 30, n);
    chk("unstable_release_edges", n, 10);
    chk("unstable_loss", int'(lock_loss_cnt), 0);

    // Loss in RUN
    @(negedge CLK);
    pll_lock = 1'b0;
    wait_for(0, 1'b1, 10, n);
    chk("loss_assert_edges", n, 3);
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    chk("loss_count_one", int'(lock_loss_cnt), 1);
    pll_lock = 1'b1;
    wait_for(0, 1'b0, 30, n);
    chk("loss_rerelease_edges", n, 10);

    // Soft reset re-runs hold only
    @(negedge CLK);
    soft_reset_req = 1'b1;
    wait_for(0, 1'b1, 5, n);
    soft_reset_req = 1'b0;
    chk("soft_assert_edges", n, 1);
    wait_for(0, 1'b0, 10, n);
    chk("soft_hold_edges", n, 3);

    // Soft request coincident with lock loss
    @(negedge CLK);
    pll_lock = 1'b0;
    repeat (2) @(negedge CLK);
    soft_reset_req = 1'b1;
    @(posedge CLK);
    #2;
    soft_reset_req = 1'b0;
    chk("coincident_sys_reset", int'(sys_reset), 1);
    chk("coincident_loss", int'(lock_loss_cnt), 2);
    @(negedge CLK);
    pll_lock = 1'b1;
    wait_for(0, 1'b0, 30, n);
    chk("coincident_release_edges", n, 10);

    // Saturation
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      pll_lock = 1'b1;
      repeat (12) @(negedge CLK);
      pll_lock = 1'b0;
      repeat (3) @(negedge CLK);
    end
    @(negedge CLK);
    chk("loss_saturated", int'(lock_loss_cnt), 255);

    // Async reset in the middle of HOLD
    pll_lock = 1'b1;
    repeat (8) @(posedge CLK);
    #3;
    RESET = 1'b1;
    #1;
    chk("async_sys_reset", int'(sys_reset), 1);
    chk("async_ready", int'(ready), 0);
    chk("async_loss", int'(lock_loss_cnt), 0);
    @(negedge CLK);
    RESET = 1'b0;

    // Randomized lock segments with sporadic soft requests
    for (int s = 0; s < 120; s++) begin
      hi_len = $urandom_range(3, 25);
      lo_len = $urandom_range(1, 4);
      pll_lock = 1'b1;
      for (int c = 0; c < hi_len; c++) begin
        soft_reset_req = ($urandom_range(0, 11) == 0);
        @(negedge CLK);
      end
      soft_reset_req = 1'b0;
      pll_lock = 1'b0;
      for (int c = 0; c < lo_len; c++) begin
        soft_reset_req = ($urandom_range(0, 5) == 0);
        @(negedge CLK);
      end
      soft_reset_req = 1'b0;
    end
    pll_lock = 1'b1;
    repeat (20) @(negedge CLK);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
